// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (CPU / DMA) arbiter onto one data-memory port with burst
//            lock and a write-protected peripheral window for the DMA port.
//            Optional macro DMEM_ARB_RR_EN: round-robin unlocked contention.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int unsigned MAX_BURST   = 4,
    parameter logic [31:0] PERIPH_BASE = 32'hC000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_lock,
    input  logic [31:0] c_a,
    input  logic [31:0] c_wd,
    output logic        c_gnt,
    output logic [31:0] c_rd,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_lock,
    input  logic [31:0] d_a,
    input  logic [31:0] d_wd,
    output logic        d_gnt,
    output logic [31:0] d_rd,
    output logic        d_rvalid,
    output logic        d_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0] mem_a_q, mem_wd_q;
    logic [31:0] c_rd_q, d_rd_q;
    logic        c_rvalid_q, d_rvalid_q, d_err_q;

    logic        hold_c, hold_d;
    logic        d_periph;

    // Unsigned offset test also behaves correctly if the window sits at the top of the map
    assign d_periph = ((d_a - PERIPH_BASE) < 32'd256);

    assign hold_c = (state_q == OWN_C) && c_req && c_lock && (burst_cnt_q < MAX_CNT);
    assign hold_d = (state_q == OWN_D) && d_req && d_lock && (burst_cnt_q < MAX_CNT);

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (hold_c) begin
                c_gnt = 1'b1;
            end else if (hold_d) begin
                d_gnt = 1'b1;
            end else if (c_req && d_req) begin
                // Owner still locked here means its burst is exhausted: hand over
                if (state_q == OWN_C && c_lock) begin
                    d_gnt = 1'b1;
                end else if (state_q == OWN_D && d_lock) begin
                    c_gnt = 1'b1;
                end else begin
`ifdef DMEM_ARB_RR_EN
                    if (state_q == OWN_C) d_gnt = 1'b1;
                    else                  c_gnt = 1'b1;
`else
                    c_gnt = 1'b1;
`endif
                end
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = IDLE;
        burst_cnt_d = burst_cnt_q;
        if (c_gnt) begin
            state_d = OWN_C;
            if (state_q == OWN_C && c_lock)
                burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + 4'd1 : burst_cnt_q;
            else
                burst_cnt_d = 4'd1;
        end else if (d_gnt) begin
            state_d = OWN_D;
            if (state_q == OWN_D && d_lock)
                burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + 4'd1 : burst_cnt_q;
            else
                burst_cnt_d = 4'd1;
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = mem_a_q;
        mem_wd = mem_wd_q;
        if (c_gnt) begin
            mem_we = c_we;
            mem_a  = c_a;
            mem_wd = c_wd;
        end else if (d_gnt) begin
            mem_we = d_we && !d_periph;
            mem_a  = d_a;
            mem_wd = d_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            mem_a_q     <= 32'd0;
            mem_wd_q    <= 32'd0;
            c_rd_q      <= 32'd0;
            d_rd_q      <= 32'd0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            if (c_gnt || d_gnt) begin
                mem_a_q  <= mem_a;
                mem_wd_q <= mem_wd;
            end
            c_rvalid_q <= c_gnt && !c_we;
            d_rvalid_q <= d_gnt && !d_we;
            d_err_q    <= d_gnt && d_we && d_periph;
            if (c_gnt && !c_we) c_rd_q <= mem_rd;
            if (d_gnt && !d_we) d_rd_q <= mem_rd;
        end
    end

    assign c_rd     = c_rd_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rd     = d_rd_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a small RAM and
//            LED-register model behind the shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, c_lock;
    logic [31:0] c_a, c_wd;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rd;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_a, d_wd;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rd;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] ram [0:63];
    logic [31:0] led_q;

    int checks = 0;
    int passes = 0;

    dmem_arbiter #(.MAX_BURST(4), .PERIPH_BASE(32'hC000_0000)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_a(c_a), .c_wd(c_wd),
        .c_gnt(c_gnt), .c_rd(c_rd), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_a(d_a), .d_wd(d_wd),
        .d_gnt(d_gnt), .d_rd(d_rd), .d_rvalid(d_rvalid), .d_err(d_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we && mem_a < 32'd256) ram[mem_a[7:2]] <= mem_wd;
        if (mem_we && mem_a == 32'hC000_0004) led_q <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c_req = 0; c_we = 0; c_lock = 0; c_a = 0; c_wd = 0;
        d_req = 0; d_we = 0; d_lock = 0; d_a = 0; d_wd = 0;
    endtask

    logic [31:0] wr_addr [0:4];
    logic        wr_err  [0:4];
    logic        exp_cg  [0:3];

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
        ram[4] = 32'hDEAD_BEEF;
        led_q  = 32'd0;
        clear_inputs();
        reset = 1;

        // Reset: registered outputs cleared, grants and writes suppressed
        tick(); tick();
        c_req = 1; c_we = 1; c_a = 32'h20; c_wd = 32'h55;
        #1;
        check("rst_c_gnt", {31'd0, c_gnt}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_c_rvalid", {31'd0, c_rvalid}, 0);
        check("rst_d_rvalid", {31'd0, d_rvalid}, 0);
        check("rst_d_err", {31'd0, d_err}, 0);
        check("rst_c_rd", c_rd, 0);
        check("rst_d_rd", d_rd, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wd", mem_wd, 0);

        // CPU read of RAM[4]
        tick();
        reset = 0;
        clear_inputs();
        c_req = 1; c_a = 32'h10;
        #1;
        check("rd_c_gnt", {31'd0, c_gnt}, 1);
        check("rd_d_gnt", {31'd0, d_gnt}, 0);
        check("rd_mem_a", mem_a, 32'h10);
        check("rd_mem_we", {31'd0, mem_we}, 0);
        tick();
        c_req = 0;
        #1;
        check("rd_c_rvalid", {31'd0, c_rvalid}, 1);
        check("rd_c_rd", c_rd, 32'hDEAD_BEEF);
        tick(); #1;
        check("rd_rvalid_pulse", {31'd0, c_rvalid}, 0);
        check("idle_mem_a_hold", mem_a, 32'h10);

        // CPU write
        c_req = 1; c_we = 1; c_a = 32'h20; c_wd = 32'h1234;
        #1;
        check("wr_mem_we", {31'd0, mem_we}, 1);
        check("wr_mem_wd", mem_wd, 32'h1234);
        tick();
        clear_inputs();
        #1;
        check("wr_no_rvalid", {31'd0, c_rvalid}, 0);
        check("wr_ram", ram[8], 32'h1234);

        // Unlocked contention for four cycles from IDLE
`ifdef DMEM_ARB_RR_EN
        exp_cg[0] = 1; exp_cg[1] = 0; exp_cg[2] = 1; exp_cg[3] = 0;
`else
        exp_cg[0] = 1; exp_cg[1] = 1; exp_cg[2] = 1; exp_cg[3] = 1;
`endif
        tick();
        c_req = 1; c_a = 32'h10; d_req = 1; d_a = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_c_gnt%0d", i), {31'd0, c_gnt}, {31'd0, exp_cg[i]});
            check($sformatf("cont_d_gnt%0d", i), {31'd0, d_gnt}, {31'd0, !exp_cg[i]});
            tick();
        end
        clear_inputs();

        // Locked DMA burst: four DMA grants, then forced handover to CPU
        tick();
        d_req = 1; d_lock = 1; d_a = 32'h10;
        #1;
        check("lk_d_gnt0", {31'd0, d_gnt}, 1);
        tick();
        c_req = 1; c_a = 32'h20;
        #1;
        check("lk_d_rvalid", {31'd0, d_rvalid}, 1);
        check("lk_d_rd", d_rd, 32'hDEAD_BEEF);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("lk_d_gnt%0d", i), {31'd0, d_gnt}, 1);
            check($sformatf("lk_c_gnt%0d", i), {31'd0, c_gnt}, 0);
            tick(); #1;
        end
        check("lk_handover_c", {31'd0, c_gnt}, 1);
        check("lk_handover_d", {31'd0, d_gnt}, 0);
        tick();
        clear_inputs();

        // DMA writes around the peripheral window
        wr_addr[0] = 32'hC000_0004; wr_err[0] = 1;
        wr_addr[1] = 32'hC000_00FF; wr_err[1] = 1;
        wr_addr[2] = 32'hC000_0100; wr_err[2] = 0;
        wr_addr[3] = 32'hBFFF_FFFC; wr_err[3] = 0;
        wr_addr[4] = 32'h0000_0030; wr_err[4] = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            d_req = 1; d_we = 1; d_a = wr_addr[i]; d_wd = 32'h3FF;
            #1;
            check($sformatf("pw_d_gnt%0d", i), {31'd0, d_gnt}, 1);
            check($sformatf("pw_mem_we%0d", i), {31'd0, mem_we}, {31'd0, !wr_err[i]});
            tick();
            clear_inputs();
            #1;
            check($sformatf("pw_d_err%0d", i), {31'd0, d_err}, {31'd0, wr_err[i]});
        end
        check("pw_led", led_q, 0);
        check("pw_ram", ram[12], 32'h3FF);
        tick(); #1;
        check("pw_err_pulse", {31'd0, d_err}, 0);

        // Reset in cycle 2 of a locked DMA burst
        d_req = 1; d_lock = 1; d_a = 32'h10;
        #1;
        check("rb_d_gnt", {31'd0, d_gnt}, 1);
        tick();
        reset = 1;
        #1;
        check("rb_gnt_forced", {31'd0, d_gnt}, 0);
        tick();
        reset = 0;
        d_lock = 0; c_req = 1; c_a = 32'h10;
        #1;
        check("rb_d_rvalid", {31'd0, d_rvalid}, 0);
        check("rb_c_gnt", {31'd0, c_gnt}, 1);
        check("rb_d_gnt_after", {31'd0, d_gnt}, 0);
        tick();
        clear_inputs();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
